// File: rtl/user_dma_pkg.sv
// user_dma shared types: OBI bundles, address map, register offsets
// and the copy-engine FSM state encoding.
package user_dma_pkg;

  localparam int unsigned ObiIdW = 4;

  typedef struct packed {
    logic              req;
    logic [31:0]       addr;
    logic              we;
    logic [3:0]        be;
    logic [31:0]       wdata;
    logic [ObiIdW-1:0] aid;
  } obi_req_t;

  typedef struct packed {
    logic              gnt;
    logic              rvalid;
    logic [31:0]       rdata;
    logic              err;
    logic [ObiIdW-1:0] rid;
  } obi_rsp_t;

  localparam logic [31:0] UserDmaAddrOffset = 32'h2000_2000;
  localparam logic [31:0] UserDmaAddrRange  = 32'h0000_1000;

  localparam int unsigned NumUserDomainManagers = 1;

  // Word offsets inside the register window
  localparam logic [9:0] RegSrc    = 10'd0;
  localparam logic [9:0] RegDst    = 10'd1;
  localparam logic [9:0] RegLen    = 10'd2;
  localparam logic [9:0] RegCtrl   = 10'd3;
  localparam logic [9:0] RegStatus = 10'd4;

  typedef enum logic [2:0] {
    DmaIdle,
    DmaRdReq,
    DmaRdWait,
    DmaWrReq,
    DmaWrWait
  } user_dma_state_e;

endpackage

// File: rtl/user_dma_reg_if.sv
// user_dma register window: OBI subordinate decode, SRC/DST/LEN/CTRL/STATUS.
// Ports: sbr OBI in/out, busy/set_done/set_error in, config + start out.
module user_dma_reg_if
  import user_dma_pkg::*;
#(
  parameter type sbr_obi_req_t = obi_req_t,
  parameter type sbr_obi_rsp_t = obi_rsp_t
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  sbr_obi_req_t sbr_obi_req_i,
  output sbr_obi_rsp_t sbr_obi_rsp_o,
  input  logic         busy_i,
  input  logic         set_done_i,
  input  logic         set_error_i,
  output logic [31:0]  src_o,
  output logic [31:0]  dst_o,
  output logic [31:0]  len_o,
  output logic         irq_en_o,
  output logic         start_o,
  output logic         done_o
);

  logic [31:0]  src_q, src_d;
  logic [31:0]  dst_q, dst_d;
  logic [31:0]  len_q, len_d;
  logic         irq_en_q, irq_en_d;
  logic         done_q, done_d;
  logic         error_q, error_d;
  sbr_obi_rsp_t rsp_q, rsp_d;

  logic        acc, wr, rd, mapped;
  logic [9:0]  woff;
  logic [31:0] wdata, rdata;

  assign acc    = sbr_obi_req_i.req;
  assign wr     = acc & sbr_obi_req_i.we;
  assign rd     = acc & ~sbr_obi_req_i.we;
  assign woff   = sbr_obi_req_i.addr[11:2];
  assign wdata  = sbr_obi_req_i.wdata;
  assign mapped = (woff <= RegStatus);

  assign start_o = wr && (woff == RegCtrl)
                && wdata[0] && !busy_i;

  always_comb begin
    rdata = '0;
    unique case (1'b1)
      woff == RegSrc:    rdata = src_q;
      woff == RegDst:    rdata = dst_q;
      woff == RegLen:    rdata = len_q;
      woff == RegCtrl:   rdata = {30'd0, irq_en_q, 1'b0};
      woff == RegStatus: rdata = {29'd0, error_q, done_q, busy_i};
      default:           rdata = '0;
    endcase
  end

  always_comb begin
    src_d    = src_q;
    dst_d    = dst_q;
    len_d    = len_q;
    irq_en_d = irq_en_q;
    done_d   = done_q;
    error_d  = error_q;
    if (wr && !busy_i) begin
      if (woff == RegSrc) src_d = {wdata[31:2], 2'b00};
      if (woff == RegDst) dst_d = {wdata[31:2], 2'b00};
      if (woff == RegLen) len_d = {wdata[31:2], 2'b00};
    end
    if (wr && woff == RegCtrl) irq_en_d = wdata[1];
    if (start_o) begin
      done_d  = 1'b0;
      error_d = 1'b0;
    end
    if (wr && woff == RegStatus) begin
      if (wdata[1]) done_d  = 1'b0;
      if (wdata[2]) error_d = 1'b0;
    end
    // FSM events beat a same-cycle software clear
    if (set_done_i)  done_d  = 1'b1;
    if (set_error_i) error_d = 1'b1;

    rsp_d        = '0;
    rsp_d.rvalid = acc;
    rsp_d.rid    = sbr_obi_req_i.aid;
    rsp_d.err    = acc & ~mapped;
    rsp_d.rdata  = (rd && mapped) ? rdata : '0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      src_q    <= '0;
      dst_q    <= '0;
      len_q    <= '0;
      irq_en_q <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
      rsp_q    <= '0;
    end else begin
      src_q    <= src_d;
      dst_q    <= dst_d;
      len_q    <= len_d;
      irq_en_q <= irq_en_d;
      done_q   <= done_d;
      error_q  <= error_d;
      rsp_q    <= rsp_d;
    end
  end

  always_comb begin
    sbr_obi_rsp_o     = rsp_q;
    sbr_obi_rsp_o.gnt = 1'b1;
  end

  assign src_o    = src_q;
  assign dst_o    = dst_q;
  assign len_o    = len_q;
  assign irq_en_o = irq_en_q;
  assign done_o   = done_q;

  logic unused_sbr;
  assign unused_sbr = ^{sbr_obi_req_i.be,
                        sbr_obi_req_i.addr[31:12],
                        sbr_obi_req_i.addr[1:0]};

endmodule

// File: rtl/user_dma.sv
// user_dma: single-channel word copy engine (OBI manager + register window).
// Ports: clk_i, rst_i, sbr OBI req/rsp, mgr OBI req/rsp, irq_o.
module user_dma
  import user_dma_pkg::*;
#(
  parameter type sbr_obi_req_t = obi_req_t,
  parameter type sbr_obi_rsp_t = obi_rsp_t,
  parameter type mgr_obi_req_t = obi_req_t,
  parameter type mgr_obi_rsp_t = obi_rsp_t
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  sbr_obi_req_t sbr_obi_req_i,
  output sbr_obi_rsp_t sbr_obi_rsp_o,
  output mgr_obi_req_t mgr_obi_req_o,
  input  mgr_obi_rsp_t mgr_obi_rsp_i,
  output logic         irq_o
);

  logic [31:0] cfg_src, cfg_dst, cfg_len;
  logic        cfg_irq_en, start, done;
  logic        busy, set_done, set_error;

  user_dma_state_e state_q, state_d;
  logic [31:0]     src_q, src_d;
  logic [31:0]     dst_q, dst_d;
  logic [31:0]     buf_q, buf_d;
  logic [29:0]     cnt_q, cnt_d;
  logic            zero_q, zero_d;

  user_dma_reg_if #(
    .sbr_obi_req_t (sbr_obi_req_t),
    .sbr_obi_rsp_t (sbr_obi_rsp_t)
  ) u_reg_if (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .sbr_obi_req_i (sbr_obi_req_i),
    .sbr_obi_rsp_o (sbr_obi_rsp_o),
    .busy_i        (busy),
    .set_done_i    (set_done),
    .set_error_i   (set_error),
    .src_o         (cfg_src),
    .dst_o         (cfg_dst),
    .len_o         (cfg_len),
    .irq_en_o      (cfg_irq_en),
    .start_o       (start),
    .done_o        (done)
  );

  assign busy  = (state_q != DmaIdle);
  assign irq_o = done & cfg_irq_en;

  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    dst_d     = dst_q;
    buf_d     = buf_q;
    cnt_d     = cnt_q;
    zero_d    = 1'b0;
    // zero-length start reports done one cycle after acceptance
    set_done  = zero_q;
    set_error = 1'b0;
    unique case (state_q)
      DmaIdle: begin
        if (start) begin
          if (cfg_len[31:2] != 30'd0) begin
            state_d = DmaRdReq;
            src_d   = cfg_src;
            dst_d   = cfg_dst;
            cnt_d   = cfg_len[31:2];
          end else begin
            zero_d  = 1'b1;
          end
        end
      end
      DmaRdReq: begin
        if (mgr_obi_rsp_i.gnt) state_d = DmaRdWait;
      end
      DmaRdWait: begin
        if (mgr_obi_rsp_i.rvalid) begin
          buf_d = mgr_obi_rsp_i.rdata;
          if (mgr_obi_rsp_i.err) begin
            set_error = 1'b1;
            state_d   = DmaIdle;
          end else begin
            state_d   = DmaWrReq;
          end
        end
      end
      DmaWrReq: begin
        if (mgr_obi_rsp_i.gnt) state_d = DmaWrWait;
      end
      DmaWrWait: begin
        if (mgr_obi_rsp_i.rvalid) begin
          if (mgr_obi_rsp_i.err) begin
            set_error = 1'b1;
            state_d   = DmaIdle;
          end else begin
            src_d = src_q + 32'd4;
            dst_d = dst_q + 32'd4;
            cnt_d = cnt_q - 30'd1;
            if (cnt_q == 30'd1) begin
              set_done = 1'b1;
              state_d  = DmaIdle;
            end else begin
              state_d  = DmaRdReq;
            end
          end
        end
      end
      default: state_d = DmaIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= DmaIdle;
      src_q   <= '0;
      dst_q   <= '0;
      buf_q   <= '0;
      cnt_q   <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      zero_q  <= zero_d;
    end
  end

  // Outputs depend only on registered state, so they hold until gnt
  always_comb begin
    mgr_obi_req_o       = '0;
    mgr_obi_req_o.req   = (state_q == DmaRdReq)
                       || (state_q == DmaWrReq);
    mgr_obi_req_o.we    = (state_q == DmaWrReq);
    mgr_obi_req_o.be    = 4'hF;
    mgr_obi_req_o.addr  = (state_q == DmaWrReq) ? dst_q : src_q;
    mgr_obi_req_o.wdata = buf_q;
  end

  logic unused_top;
  assign unused_top = ^{cfg_len[1:0], mgr_obi_rsp_i.rid};

endmodule

// File: doc/user_dma.md
# user_dma

Single-channel word-copy engine in the user domain. It is the first user-domain OBI **manager**: it reads 32-bit words from a source region and writes them to a destination region over the crossbar. It is configured through its own OBI **subordinate** register window, which is mapped into the user demux next to the advanced timer.

## Interface
- `SbrObiCfg`, default `croc_pkg::SbrObiCfg`: OBI config of the subordinate (register) port.
- `MgrObiCfg`, default `croc_pkg::MgrObiCfg`: OBI config of the manager (data) port.
- `sbr_obi_req_t`, `sbr_obi_rsp_t`, `mgr_obi_req_t`, `mgr_obi_rsp_t`: OBI struct types matching the configs.
- `clk_i`  in  1  clock; the only clock.
- `rst_i`  in  1  reset; synchronous and active-high.
- `sbr_obi_req_i`  in  struct  register access request.
- `sbr_obi_rsp_o`  out  struct  register access response.
- `mgr_obi_req_o`  out  struct  data-path request to the crossbar.
- `mgr_obi_rsp_i`  in  struct  data-path response.
- `irq_o`  out  1  level interrupt, equal to `STATUS.done & CTRL.irq_en`.

## Operation
- **Registers** (word offsets; byte offset bits [1:0] ignored):
  - `0x00 SRC`: source address.
  - `0x04 DST`: destination address.
  - `0x08 LEN`: byte count.
  - `0x0C CTRL`: bit0 `start` (write-1 pulse, reads as 0), bit1 `irq_en`.
  - `0x10 STATUS`: bit0 `busy` (RO), bit1 `done` (W1C), bit2 `error` (W1C).
- **Alignment:** bits [1:0] of SRC, DST and LEN are forced to 0 on write. The word count is `LEN>>2`.
- **Subordinate port:**
  - `gnt` is tied to 1.
  - `rvalid` follows one cycle after an accepted request and echoes `aid` as `rid`.
  - An unmapped offset returns `err=1`, `rdata=0`.
  - A write to an unmapped offset has no effect.
- **Writes while busy:** writes to SRC, DST or LEN while `busy=1` are ignored with no error. A `start` while busy is ignored.
- **FSM states:** IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT.
  - **IDLE → RD_REQ** on an accepted `start` with word count ≠ 0. Copies SRC, DST and the word count into working counters, and clears `done` and `error`.
  - **Zero-length start:** with word count = 0, the FSM stays in IDLE and sets `done` one cycle later.
  - **RD_REQ:** drives `req=1`, `we=0`, `be=4'hF`, `addr=cur_src`. Moves to RD_WAIT on `gnt`.
  - **RD_WAIT:** on `rvalid` captures `rdata` into a 32-bit buffer.
    - If `err`, sets `error` and goes to IDLE without setting `done`.
    - Otherwise goes to WR_REQ.
  - **WR_REQ:** drives `req=1`, `we=1`, `be=4'hF`, `addr=cur_dst`, `wdata=buffer`. Moves to WR_WAIT on `gnt`.
  - **WR_WAIT:** on `rvalid`:
    - If `err`, sets `error` and goes to IDLE.
    - Otherwise adds 4 to `cur_src` and `cur_dst` (mod 2^32, wrap allowed) and decrements the remaining count.
    - When the count reaches 0, sets `done` and goes to IDLE; otherwise goes to RD_REQ.
- **Request stability:** `req`, `addr`, `we`, `be` and `wdata` are held stable from assertion until `gnt`. At most one transaction is outstanding.
- **Response filtering:** `mgr_obi_rsp_i.rvalid` is ignored in IDLE, RD_REQ and WR_REQ.
- **W1C vs. internal set:** if software clears `done`/`error` in the same cycle the FSM sets it, the set wins.
- **Reset values:** SRC=DST=LEN=0, CTRL=0, STATUS=0, FSM=IDLE, `mgr_obi_req_o.req=0`, `sbr_obi_rsp_o.rvalid=0`, `irq_o=0`.
- **Reset mid-transfer:** returns everything to reset values on the next edge. A response still in flight from the crossbar is discarded.

## Timing
- **Start latency:** a start accepted in cycle t puts RD_REQ (`req=1`) in cycle t+1.
- **Zero-wait-state fabric** (gnt with req, rvalid one cycle later): 4 cycles per word. The cycle pattern is read req, read rvalid, write req, write rvalid.
- **Done timing:** `done` and `irq_o` become visible the cycle after the final write `rvalid`.
- **STATUS readback:** a STATUS read returns the value registered at request acceptance.
- **Wait states:** `gnt` stalls and `rvalid` delays extend the relevant state by exactly the stall length.

## Structure
- Additions to `user_pkg`:
  - `UserDmaAddrOffset = 32'h2000_2000`, `UserDmaAddrRange = 32'h0000_1000`.
  - Enum entry `UserDma = 1`; `NumUserDomainSubordinates` becomes 2, with the matching `user_addr_map` rule.
  - `NumUserDomainManagers = 1`.
  - Register offset localparams.
  - The FSM state enum `user_dma_state_e`.
- Sub-module `user_dma_reg_if`: subordinate decode, the register file and W1C logic. The top level holds the FSM and the counters.

## Test plan
- SRC=0x1000_0000, DST=0x1000_0100, LEN=16, zero-wait memory → 4 words copied in order. `done=1` 17 cycles after the start cycle. `irq_o=1` with `irq_en=1`.
- LEN=0 with start → no manager request. STATUS reads 0x2.
- Random `gnt` stalls of 0–5 cycles, LEN=32 → `addr`, `we` and `wdata` are stable while stalled. Copied data matches. Exactly 16 granted requests.
- Write response `err=1` on word 2 of LEN=16 → STATUS=0x4, `done=0`, FSM back in IDLE. Only 2 writes issued.
- Write SRC=0xFFFF_FFFC, LEN=8 → second read address is 0x0000_0000. Writing SRC/LEN while busy is ignored. A second start while busy is ignored.
- Assert `rst_i` during WR_WAIT, then deliver the pending `rvalid` → ignored. All registers read 0. `irq_o=0`.
